// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Optional statistics counters in the top are enabled with RF_ARB_STATS_EN.
package rf_arb_pkg;
  localparam int NBITS = 32;
  localparam int NREG  = 32;
  localparam int AW    = $clog2(NREG);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [NBITS-1:0] data;
  } wb_req_t;

  // Round-robin pointer: which requester wins the next two-way conflict.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request channels (ALU = req0, LSU = req1) and register-file write port.
// Handshake: a request transfers on a cycle where reqN_valid & reqN_ready; ready never waits on a transfer.
interface regfile_wr_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int nbits      = NBITS,
  parameter int nregisters = NREG
);
  localparam int aw = $clog2(nregisters);

  logic             req0_valid;
  logic [aw-1:0]    req0_addr;
  logic [nbits-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [aw-1:0]    req1_addr;
  logic [nbits-1:0] req1_data;
  logic             req1_ready;
  logic             wr;
  logic [aw-1:0]    add_wr;
  logic [nbits-1:0] datain;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr, add_wr, datain
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr, add_wr, datain
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances only on a grant.
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       stall,
  output logic [1:0] gnt,
  output rr_state_t  rr_state
);
  rr_state_t rr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_state <= RR_REQ0;
    else     rr_state <= rr_next;
  end

  always_comb begin
    gnt     = 2'b00;
    rr_next = rr_state;
    // Reset gates the grant so nothing is accepted in the cycle reset rises.
    if (!stall && !rst) begin
      if (req == 2'b11) gnt = (rr_state == RR_REQ0) ? 2'b01 : 2'b10;
      else              gnt = req;
      if (gnt[0])      rr_next = RR_REQ1;
      else if (gnt[1]) rr_next = RR_REQ0;
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU/LSU writebacks onto one register-file write port, one cycle latency.
// Define RF_ARB_STATS_EN to add saturating grant/conflict counters.
module regfile_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int nbits      = NBITS,
  parameter int nregisters = NREG
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  regfile_wr_arbiter_if.slave  bus,
  output rr_state_t            rr_dbg
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1,
  output logic [15:0]          conflict_cnt
`endif
);
  localparam int aw = $clog2(nregisters);

  logic [1:0]       gnt;
  logic [aw-1:0]    sel_addr;
  logic [nbits-1:0] sel_data;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      ({bus.req1_valid, bus.req0_valid}),
    .stall    (stall),
    .gnt      (gnt),
    .rr_state (rr_dbg)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    sel_addr = bus.req0_addr;
    sel_data = bus.req0_data;
    if (gnt[1]) begin
      sel_addr = bus.req1_addr;
      sel_data = bus.req1_data;
    end
  end

  // Register x0 is hardwired: its writes are accepted but never strobed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr     <= 1'b0;
      bus.add_wr <= '0;
      bus.datain <= '0;
    end else if (|gnt) begin
      bus.wr     <= (sel_addr != '0);
      bus.add_wr <= sel_addr;
      bus.datain <= sel_data;
    end else begin
      bus.wr     <= 1'b0;
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt[0]) grant_cnt0 <= sat_inc16(grant_cnt0);
      if (gnt[1]) grant_cnt1 <= sat_inc16(grant_cnt1);
      if (bus.req0_valid && bus.req1_valid && !stall)
        conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected writes queued by the driver, popped by a monitor.
module tb_regfile_wr_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  rr_state_t rr_dbg;
`ifdef RF_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  int vectors = 0;
  int fails   = 0;
  logic [AW+NBITS-1:0] exp_q[$];

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .bus    (bus),
    .rr_dbg (rr_dbg)
`ifdef RF_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic wb_req_t mk(input logic v, input logic [AW-1:0] a, input logic [NBITS-1:0] d);
    wb_req_t r;
    r.valid = v;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input wb_req_t r0, input wb_req_t r1, input logic st);
    bus.req0_valid = r0.valid;
    bus.req0_addr  = r0.addr;
    bus.req0_data  = r0.data;
    bus.req1_valid = r1.valid;
    bus.req1_addr  = r1.addr;
    bus.req1_data  = r1.data;
    stall          = st;
  endtask

  // One arbitration cycle: drive at negedge, check readys, queue the write it should produce.
  task automatic step(input string name, input wb_req_t r0, input wb_req_t r1, input logic st,
                      input logic [1:0] exp_rdy, input logic exp_wr,
                      input logic [AW-1:0] ea, input logic [NBITS-1:0] ed);
    @(negedge clk);
    drive(r0, r1, st);
    #1;
    check(name, {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, exp_rdy});
    if (exp_wr) exp_q.push_back({ea, ed});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle_rdy", mk(0, 0, 0), mk(0, 0, 0), 1'b0, 2'b00, 1'b0, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.wr) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_wr: got add_wr=%0d datain=%h expected no write", bus.add_wr, bus.datain);
      end else begin
        logic [AW+NBITS-1:0] e;
        e = exp_q.pop_front();
        if ({bus.add_wr, bus.datain} !== e) begin
          fails++;
          $display("FAIL wr_data: got add_wr=%0d datain=%h expected add_wr=%0d datain=%h",
                   bus.add_wr, bus.datain, e[AW+NBITS-1:NBITS], e[NBITS-1:0]);
        end
      end
    end
  end

  initial begin
    drive(mk(1, 5, 32'h1), mk(1, 6, 32'h2), 1'b0);
    #3;
    check("rst_wr",     {63'd0, bus.wr}, 64'd0);
    check("rst_add_wr", {59'd0, bus.add_wr}, 64'd0);
    check("rst_datain", {32'd0, bus.datain}, 64'd0);
    check("rst_ready",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    check("rst_rr",     {63'd0, rr_dbg}, 64'd0);
    @(negedge clk);
    drive(mk(0, 0, 0), mk(0, 0, 0), 1'b0);
    rst = 1'b0;

    // alternating conflict from reset: req0 first
    step("rr_c1", mk(1, 1, 32'h11), mk(1, 2, 32'h22), 0, 2'b01, 1, 1, 32'h11);
    step("rr_c2", mk(1, 1, 32'h11), mk(1, 2, 32'h22), 0, 2'b10, 1, 2, 32'h22);
    step("rr_c3", mk(1, 1, 32'h11), mk(1, 2, 32'h22), 0, 2'b01, 1, 1, 32'h11);
    step("rr_c4", mk(1, 1, 32'h11), mk(1, 2, 32'h22), 0, 2'b10, 1, 2, 32'h22);
    // single requester
    step("solo0", mk(1, 5, 32'hDEADBEEF), mk(0, 0, 0), 0, 2'b01, 1, 5, 32'hDEADBEEF);
    // x0 write accepted, no strobe
    step("x0_wr", mk(0, 0, 0), mk(1, 0, 32'h12345678), 0, 2'b10, 0, 0, 0);
    // stall holds both off; pointer now favours req0
    step("stall1", mk(1, 7, 32'h77), mk(1, 8, 32'h88), 1, 2'b00, 0, 0, 0);
    step("stall2", mk(1, 7, 32'h77), mk(1, 8, 32'h88), 1, 2'b00, 0, 0, 0);
    step("stall3", mk(1, 7, 32'h77), mk(1, 8, 32'h88), 1, 2'b00, 0, 0, 0);
    step("unstall", mk(1, 7, 32'h77), mk(1, 8, 32'h88), 0, 2'b01, 1, 7, 32'h77);
    // loser served next; req0 data changing meanwhile must not leak
    step("loser", mk(1, 7, 32'h99), mk(1, 8, 32'h88), 0, 2'b10, 1, 8, 32'h88);
    // same-address conflict: winner then loser, last write wins
    step("same_a", mk(1, 9, 32'hAAAA), mk(1, 9, 32'hBBBB), 0, 2'b01, 1, 9, 32'hAAAA);
    step("same_b", mk(0, 0, 0), mk(1, 9, 32'hBBBB), 0, 2'b10, 1, 9, 32'hBBBB);
    step("solo1", mk(0, 0, 0), mk(1, 3, 32'h33), 0, 2'b10, 1, 3, 32'h33);
    idle(1);

    // reset during a grant cycle
    step("pre_rst", mk(1, 4, 32'h44), mk(0, 0, 0), 0, 2'b01, 1, 4, 32'h44);
    step("rst_gnt", mk(0, 0, 0), mk(1, 6, 32'h66), 0, 2'b10, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_wr",     {63'd0, bus.wr}, 64'd0);
    check("mid_rst_add_wr", {59'd0, bus.add_wr}, 64'd0);
    check("mid_rst_datain", {32'd0, bus.datain}, 64'd0);
    check("mid_rst_ready",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    check("mid_rst_rr",     {63'd0, rr_dbg}, 64'd0);
    @(negedge clk);
    drive(mk(0, 0, 0), mk(0, 0, 0), 1'b0);
    rst = 1'b0;
    idle(2);
    step("post_rst", mk(1, 10, 32'hA0), mk(1, 11, 32'hB0), 0, 2'b01, 1, 10, 32'hA0);
    idle(2);

`ifdef RF_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("st_c1", mk(1, 1, 32'h1), mk(1, 2, 32'h2), 0, 2'b01, 1, 1, 32'h1);
    step("st_c2", mk(1, 1, 32'h1), mk(1, 2, 32'h2), 0, 2'b10, 1, 2, 32'h2);
    step("st_c3", mk(1, 1, 32'h1), mk(1, 2, 32'h2), 0, 2'b01, 1, 1, 32'h1);
    idle(2);
    check("conflict_cnt", {48'd0, conflict_cnt}, 64'd3);
    check("grant_cnt0",   {48'd0, grant_cnt0}, 64'd2);
    check("grant_cnt1",   {48'd0, grant_cnt1}, 64'd1);
`endif

    idle(2);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
